// File: rtl/gray_step_arbiter.sv
// gray_step_arbiter: two-requester round-robin arbiter that steps a shared
// external 3-bit Gray counter for the winner's step count and reports the
// counter value and overflow when the count completes.
// Optional build macro GRAY_ARB_CHECK_EN adds a sticky Gray-sequence checker
// on CntOut (GrayErr); without it GrayErr is tied low.
//
// state | meaning
// IDLE  | waiting for a request; winner picked and steps latched on exit
// CLR   | one cycle clearing the shared counter
// RUN   | counter enabled once per cycle until Remaining runs out
// DONE  | result available; held DONE_HOLD cycles, pointer updated on exit
module gray_step_arbiter #(
   parameter int DONE_HOLD = 1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [1:0] Req,
   input  logic [2:0] Steps0,
   input  logic [2:0] Steps1,
   output logic [1:0] Gnt,
   output logic       Busy,
   output logic       Done,
   output logic [2:0] Result,
   output logic       Wrap,
   output logic       CntEn,
   output logic       CntReset,
   input  logic [2:0] CntOut,
   input  logic       CntOvf,
   output logic       GrayErr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] remaining;
   logic [1:0] hold_cnt;
   logic [1:0] last_gnt;
   logic [2:0] result_q;
   logic       wrap_q;
   logic [1:0] win;
   logic [2:0] steps_sel;

   // Round-robin pick: a lone requester wins, on contention the one not served last
   always_comb begin
      win = 2'b00;
      case (Req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = (last_gnt == 2'b01) ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
      steps_sel = win[1] ? Steps1 : Steps0;
   end

   // Sequencer: state, grant, step down-counter, hold timer and captured result
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         Gnt       <= 2'b00;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         CntEn     <= 1'b0;
         remaining <= 4'd0;
         hold_cnt  <= 2'd0;
         last_gnt  <= 2'b01;
         result_q  <= 3'd0;
         wrap_q    <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (win != 2'b00) begin
                  Gnt       <= win;
                  Busy      <= 1'b1;
                  remaining <= (steps_sel == 3'd0) ? 4'd8 : {1'b0, steps_sel};
                  state     <= CLR;
               end
            end
            CLR: begin
               CntEn <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               remaining <= remaining - 4'd1;
               if (remaining == 4'd1) begin
                  CntEn    <= 1'b0;
                  Done     <= 1'b1;
                  hold_cnt <= 2'(DONE_HOLD - 1);
                  state    <= DONE;
               end
            end
            DONE: begin
               if (Done) begin
                  result_q <= CntOut;
                  wrap_q   <= CntOvf;
               end
               if (hold_cnt == 2'd0) begin
                  Gnt      <= 2'b00;
                  Busy     <= 1'b0;
                  last_gnt <= Gnt;
                  state    <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt - 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The counter's last step lands on the DONE entry edge, so the first DONE
   // cycle passes CntOut/CntOvf straight through and the held copy takes over after.
   assign Result = Done ? CntOut : result_q;
   assign Wrap   = Done ? CntOvf : wrap_q;

   // Counter clears alongside the arbiter reset and during CLR
   assign CntReset = Reset | (state == CLR);

`ifdef GRAY_ARB_CHECK_EN
   logic [2:0] cnt_prev;
   logic       run_first;
   logic       gray_err_q;
   logic [2:0] cnt_diff;
   logic       chk_active;

   assign cnt_diff   = CntOut ^ cnt_prev;
   assign chk_active = ((state == RUN) && !run_first) || Done;

   // Sticky flag when a checked cycle sees CntOut move by other than one bit
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cnt_prev   <= 3'd0;
         run_first  <= 1'b0;
         gray_err_q <= 1'b0;
      end else begin
         cnt_prev  <= CntOut;
         run_first <= (state == CLR);
         if (chk_active && (cnt_diff != 3'b001) && (cnt_diff != 3'b010) &&
             (cnt_diff != 3'b100))
            gray_err_q <= 1'b1;
      end
   end

   assign GrayErr = gray_err_q;
`else
   assign GrayErr = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Bench for gray_step_arbiter: transaction-level reference model plus a Gray
// counter model, per-cycle output compare, directed scenarios and random traffic.
module tb_gray_step_arbiter;

   localparam int HOLD = 2;
`ifdef GRAY_ARB_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       Clk;
   logic       Reset;
   logic [1:0] Req;
   logic [2:0] Steps0, Steps1;
   logic [1:0] Gnt;
   logic       Busy, Done, Wrap, CntEn, CntReset, GrayErr;
   logic [2:0] Result;
   logic [2:0] CntOut;
   logic       CntOvf;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit started = 1'b0;

   gray_step_arbiter #(.DONE_HOLD(HOLD)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Steps0(Steps0), .Steps1(Steps1),
      .Gnt(Gnt), .Busy(Busy), .Done(Done), .Result(Result), .Wrap(Wrap),
      .CntEn(CntEn), .CntReset(CntReset), .CntOut(CntOut), .CntOvf(CntOvf),
      .GrayErr(GrayErr)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [2:0] gray3(input logic [2:0] b);
      return b ^ (b >> 1);
   endfunction

   // Shared counter model: binary count shown as Gray, optional corruption mask
   logic [2:0] cnt_bin = 3'd0;
   logic       cnt_ovf = 1'b0;
   logic [2:0] cnt_xor = 3'd0;
   always @(posedge Clk) begin
      if (CntReset) begin
         cnt_bin <= 3'd0;
         cnt_ovf <= 1'b0;
      end else if (CntEn) begin
         cnt_bin <= cnt_bin + 3'd1;
         if (cnt_bin == 3'd7) cnt_ovf <= 1'b1;
      end
   end
   assign CntOut = gray3(cnt_bin) ^ cnt_xor;
   assign CntOvf = cnt_ovf;

   // Reference model: one operation = offset from the accepting cycle
   bit         m_act = 1'b0;
   int         m_off = 0;
   int         m_n   = 0;
   bit         m_w   = 1'b0;
   bit         m_last = 1'b0;
   logic [2:0] m_res = 3'd0;
   logic       m_wrap = 1'b0;
   bit         m_err = 1'b0;
   logic [2:0] m_xor_prev = 3'd0;

   always @(posedge Clk) begin
      bit chkd;
      int s;
      chkd = m_act && ((m_off >= 3 && m_off <= m_n + 1) || m_off == m_n + 2);
      if (Reset) begin
         m_act = 1'b0; m_off = 0; m_last = 1'b0;
         m_res = 3'd0; m_wrap = 1'b0; m_err = 1'b0;
      end else begin
         if (CHK && chkd && (cnt_xor != m_xor_prev)) m_err = 1'b1;
         if (!m_act) begin
            if (Req != 2'b00) begin
               if (Req == 2'b01)      m_w = 1'b0;
               else if (Req == 2'b10) m_w = 1'b1;
               else                   m_w = !m_last;
               s = m_w ? int'(Steps1) : int'(Steps0);
               m_n = (s == 0) ? 8 : s;
               m_off = 1;
               m_act = 1'b1;
            end
         end else begin
            m_off++;
            if (m_off == m_n + 2) begin
               m_res  = gray3(3'(m_n % 8)) ^ cnt_xor;
               m_wrap = (m_n == 8);
            end
            if (m_off > m_n + 1 + HOLD) begin
               m_act = 1'b0;
               m_last = m_w;
            end
         end
      end
      m_xor_prev = cnt_xor;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge Clk) begin
      if (started) begin
         logic [1:0] e_gnt;
         e_gnt = m_act ? (m_w ? 2'b10 : 2'b01) : 2'b00;
         chk("gnt", Gnt, e_gnt);
         chk("busy", Busy, m_act);
         chk("cnt_en", CntEn, m_act && m_off >= 2 && m_off <= m_n + 1);
         chk("done", Done, m_act && m_off == m_n + 2);
         chk("cnt_reset", CntReset, Reset || (m_act && m_off == 1));
         chk("result", Result, m_res);
         chk("wrap", Wrap, m_wrap);
         chk("gray_err", GrayErr, m_err);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // One operation with literal expectations; drop_after<=0 keeps Req held
   task automatic do_op(input logic [1:0] req, input logic [2:0] s0, input logic [2:0] s1,
                        input int drop_after, input int exp_lat, input logic [1:0] exp_gnt,
                        input logic [2:0] exp_res, input logic exp_wrap, input int exp_en,
                        input string nm);
      int t0, en_cnt, clr_cnt;
      bit seen;
      @(posedge Clk); #1;
      Req = req; Steps0 = s0; Steps1 = s1;
      t0 = cyc; en_cnt = 0; clr_cnt = 0; seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge Clk);
         if (CntEn) en_cnt++;
         if (CntReset) clr_cnt++;
         if (Done) begin
            seen = 1'b1;
            if (exp_lat > 0) chk({nm, "_latency"}, cyc - t0, exp_lat);
            chk({nm, "_gnt"}, Gnt, exp_gnt);
            chk({nm, "_result"}, Result, exp_res);
            chk({nm, "_wrap"}, Wrap, exp_wrap);
            chk({nm, "_en_cycles"}, en_cnt, exp_en);
            chk({nm, "_clr_cycles"}, clr_cnt, 1);
         end
         if (drop_after > 0 && k == drop_after) Req = 2'b00;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no Done within 40 cycles, required one", nm);
      end
   endtask

   initial begin
      int t0, dcount;
      bit seen;
      Reset = 1'b1; Req = 2'b00; Steps0 = 3'd0; Steps1 = 3'd0;
      @(posedge Clk);
      started = 1'b1;
      @(negedge Clk);
      chk("rst_gnt", Gnt, 2'b00);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_result", Result, 3'b000);
      chk("rst_wrap", Wrap, 1'b0);
      chk("rst_cnt_en", CntEn, 1'b0);
      chk("rst_cnt_reset", CntReset, 1'b1);
      chk("rst_gray_err", GrayErr, 1'b0);
      idle(1);
      Reset = 1'b0;
      idle(2);

      // Contention alternates starting with requester 1
      do_op(2'b11, 3'd2, 3'd3, 0, 5, 2'b10, 3'b010, 1'b0, 3, "rr1");
      do_op(2'b11, 3'd2, 3'd3, 0, 0, 2'b01, 3'b011, 1'b0, 2, "rr2");
      do_op(2'b11, 3'd2, 3'd3, 0, 0, 2'b10, 3'b010, 1'b0, 3, "rr3");
      @(posedge Clk); #1; Req = 2'b00;
      idle(4);

      do_op(2'b01, 3'd5, 3'd0, 1, 7, 2'b01, 3'b111, 1'b0, 5, "s5");
      idle(3);
      do_op(2'b10, 3'd1, 3'd0, 1, 10, 2'b10, 3'b000, 1'b1, 8, "s8");
      idle(3);
      chk("result_held", Result, 3'b000);
      chk("wrap_held", Wrap, 1'b1);
      do_op(2'b01, 3'd4, 3'd6, 3, 6, 2'b01, 3'b110, 1'b0, 4, "drop");
      idle(3);

      // Reset during the third RUN cycle abandons the operation
      @(posedge Clk); #1;
      Req = 2'b01; Steps0 = 3'd6; t0 = cyc;
      @(posedge Clk); #1; Req = 2'b00;
      while (cyc < t0 + 4) begin @(posedge Clk); #1; end
      Reset = 1'b1;
      @(negedge Clk);
      chk("midrun_cnt_reset", CntReset, 1'b1);
      @(posedge Clk); #1;
      @(negedge Clk);
      chk("midrun_gnt", Gnt, 2'b00);
      chk("midrun_busy", Busy, 1'b0);
      chk("midrun_result", Result, 3'b000);
      chk("midrun_cnt_en", CntEn, 1'b0);
      @(posedge Clk); #1; Reset = 1'b0;
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge Clk);
         if (Done) dcount++;
      end
      chk("midrun_no_done", dcount, 0);
      do_op(2'b01, 3'd1, 3'd0, 1, 3, 2'b01, 3'b001, 1'b0, 1, "after_rst");
      idle(3);

      // Corrupted counter: 001 jumps to 110 mid-RUN
      @(posedge Clk); #1;
      Req = 2'b01; Steps0 = 3'd5; t0 = cyc;
      @(posedge Clk); #1; Req = 2'b00;
      while (cyc < t0 + 4) begin @(posedge Clk); #1; end
      cnt_xor = 3'b101;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge Clk);
         if (Done) begin
            seen = 1'b1;
            chk("inj_result", Result, 3'b010);
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL inj_timeout: no Done within 20 cycles, required one");
      end
      idle(HOLD + 2);
      cnt_xor = 3'b000;
      chk("inj_gray_err", GrayErr, CHK);
      do_op(2'b01, 3'd3, 3'd0, 1, 5, 2'b01, 3'b010, 1'b0, 3, "legal_after_err");
      idle(3);
      chk("gray_err_sticky", GrayErr, CHK);
      Reset = 1'b1;
      idle(1);
      Reset = 1'b0;
      @(negedge Clk);
      chk("gray_err_cleared", GrayErr, 1'b0);
      do_op(2'b10, 3'd0, 3'd7, 1, 9, 2'b10, 3'b100, 1'b0, 7, "legal_clean");
      idle(3);
      chk("gray_err_legal", GrayErr, 1'b0);

      // Random traffic checked by the per-cycle compare
      for (int i = 0; i < 3000; i++) begin
         @(posedge Clk); #1;
         Reset  = ($urandom_range(0, 199) == 0);
         Req    = 2'($urandom_range(0, 3));
         Steps0 = 3'($urandom_range(0, 7));
         Steps1 = 3'($urandom_range(0, 7));
      end
      @(posedge Clk); #1;
      Reset = 1'b0; Req = 2'b00;
      idle(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gray_step_arbiter.md
GRAY_STEP_ARBITER -- requirements
Module: gray_step_arbiter

Interface
REQ-001 Parameter: DONE_HOLD, default 1; number of cycles (1..4) spent in DONE before returning to IDLE.
REQ-002 Port: Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: Req  input  2  per-requester request; Req[i] is a level held by requester i.
REQ-005 Port: Steps0 / Steps1  input  3 each  step count for requester 0 / 1; 0 encodes 8 steps.
REQ-006 Port: Gnt  output  2  one-hot grant; at most one bit high.
REQ-007 Port: Busy  output  1  high in any state other than IDLE.
REQ-008 Port: Done  output  1  one-cycle pulse on the first DONE cycle.
REQ-009 Port: Result  output  3  Gray value captured from CntOut on entry to DONE.
REQ-010 Port: Wrap  output  1  CntOvf captured on entry to DONE.
REQ-011 Port: CntEn / CntReset  output  1 each  enable and synchronous clear driven to the shared 3-bit Gray counter.
REQ-012 Port: CntOut  input  3  Gray counter output; CntOvf  input  1  counter sticky overflow.
REQ-013 Port: GrayErr  output  1  sticky Gray-sequence error flag (see Configuration).

Function
REQ-014 The FSM SHALL have the states IDLE, CLR, RUN, and DONE, encoded in 2 bits.
REQ-015 In IDLE with Req!=0, the FSM SHALL pick a winner, latch that winner's Steps into Remaining (4 bits, 0 mapped to 8), set Gnt, and move to CLR.
REQ-016 Arbitration SHALL be round-robin: the single requester wins; if both request, the requester not served last wins; after reset, requester 0 counts as served last.
REQ-017 CLR SHALL last exactly one cycle, with CntReset=1 and CntEn=0, then go to RUN.
REQ-018 RUN SHALL drive CntEn=1 every cycle and decrement Remaining, then go to DONE after exactly N cycles (N = 1..8).
REQ-019 On the DONE entry edge, Result SHALL take CntOut, Wrap SHALL take CntOvf, and Done SHALL pulse; Result equals gray(N mod 8) and Wrap=1 only when N=8.
REQ-020 DONE SHALL last DONE_HOLD cycles; on exit, Gnt SHALL clear, the last-served pointer SHALL update to the winner, and the FSM SHALL return to IDLE.
REQ-021 Latency SHALL be fixed: Req sampled at cycle t gives CLR at t+1, RUN at t+2..t+N+1, and the first DONE cycle at t+N+2.
REQ-022 Gnt SHALL stay stable from CLR through DONE; Req and Steps changes during that time SHALL be ignored, and a dropped Req SHALL NOT abort the operation.
REQ-023 A new request SHALL NOT be accepted earlier than the first IDLE cycle after DONE; back-to-back operations SHALL be separated by at least one IDLE cycle.
REQ-024 Result and Wrap SHALL hold their value until the next DONE entry.

Reset
REQ-025 When Reset=1, the FSM SHALL go to IDLE; Gnt, Busy, Done, Result, Wrap, CntEn, Remaining, and GrayErr SHALL be 0; the last-served pointer SHALL be 1.
REQ-026 CntReset SHALL equal Reset OR (state==CLR), combinationally, so the counter clears together with the arbiter.
REQ-027 Reset asserted mid-RUN SHALL abandon the operation without a Done pulse; the next operation SHALL start cleanly from IDLE.

Configuration
REQ-028 With GRAY_ARB_CHECK_EN defined, each RUN cycle after the first and the DONE entry cycle SHALL compare CntOut with its previous-cycle value, and any Hamming distance other than 1 SHALL set GrayErr (sticky until Reset).
REQ-029 Without GRAY_ARB_CHECK_EN, GrayErr SHALL be tied 0 and no checker logic SHALL be present.

Verification
REQ-030 Scenario: Req=01, Steps0=5 -> Gnt=01, CntReset for 1 cycle, CntEn for 5 cycles, Done at t+7, Result=111, Wrap=0.
REQ-031 Scenario: Req=10, Steps1=0 -> 8 CntEn cycles, Result=000, Wrap=1.
REQ-032 Scenario: Req=11 held with Steps0=2 and Steps1=3 -> grants alternate 10, 01, 10; Results alternate 010 (Steps1=3), 011 (Steps0=2).
REQ-033 Scenario: Reset pulsed during the 3rd RUN cycle -> no Done, all outputs 0, CntReset=1 during Reset; the next Req=01 with Steps0=1 gives Result=001.
REQ-034 Scenario: GRAY_ARB_CHECK_EN defined, counter model forced to jump 001->110 -> GrayErr=1 and it stays 1 until Reset; a legal sequence leaves GrayErr=0.
REQ-035 Scenario: Req dropped during RUN -> the operation completes with the full step count and Done pulses.
